aurora_link_sequencer: RTL and testbench

- Reset/bring-up controller for the 4-lane Aurora core behind the QSFP GT pin-adapter.
- Drives the core's `pma_init` and `reset_pb` in the required order and watches `gt_pll_lock`, `lane_up` and `channel_up`.
- Declares the link good only after a debounced channel-up; re-sequences the core on timeout or channel-down, with bounded retries.
- Sits in the Vitis kernel clock domain, between kernel control logic and the Aurora core's reset/status pins.

---
 rtl/aurora_link_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_aurora_link_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_sequencer.sv
// Reset/bring-up sequencer for a 4-lane Aurora core: orders pma_init/reset_pb, debounces channel_up, retries with a bound.
// Optional statistics outputs (down_events, last_up_latency) are enabled by defining AURORA_SEQ_STATS_EN.
module aurora_link_sequencer #(
  parameter int NUM_LANES       = 4,
  parameter int PMA_INIT_CYCLES = 1024,
  parameter int RESET_PB_CYCLES = 256,
  parameter int LINK_TIMEOUT    = 1048576,
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int RETRY_MAX       = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 enable,
  input  logic                 gt_pll_lock,
  input  logic [NUM_LANES-1:0] lane_up,
  input  logic                 channel_up,
  output logic                 pma_init,
  output logic                 reset_pb,
  output logic                 link_ok,
  output logic                 fail,
  output logic [2:0]           state,
  output logic [7:0]           retry_cnt,
  output logic [NUM_LANES-1:0] lanes_up_sync
`ifdef AURORA_SEQ_STATS_EN
  ,
  output logic [15:0]          down_events,
  output logic [31:0]          last_up_latency
`endif
);

  localparam int PMA_W = $clog2(PMA_INIT_CYCLES + 1);
  localparam int PB_W  = $clog2(RESET_PB_CYCLES + 1);
  localparam int TO_W  = $clog2(LINK_TIMEOUT + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW    = NUM_LANES + 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PMA_HOLD = 3'd1,
    S_PB_HOLD  = 3'd2,
    S_WAIT_UP  = 3'd3,
    S_UP       = 3'd4,
    S_RETRY    = 3'd5,
    S_FAIL     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PMA_W-1:0] pma_tmr_q, pma_tmr_d;
  logic [PB_W-1:0]  pb_tmr_q, pb_tmr_d;
  logic [TO_W-1:0]  to_tmr_q, to_tmr_d;
  logic [DB_W-1:0]  deb_q, deb_d;
  logic [7:0]       retry_cnt_q, retry_cnt_d;
  logic             pma_init_q, pma_init_d;
  logic             reset_pb_q, reset_pb_d;
  logic             link_ok_q, link_ok_d;
  logic             fail_q, fail_d;
  logic [SW-1:0]    sync1_q, sync2_q;
  logic             lock_s, chan_s;

  // All status inputs come from the GT clock domain; two flops each before use.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {gt_pll_lock, channel_up, lane_up};
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q[SW-1];
  assign chan_s = sync2_q[NUM_LANES];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      pma_tmr_q   <= '0;
      pb_tmr_q    <= '0;
      to_tmr_q    <= '0;
      deb_q       <= '0;
      retry_cnt_q <= '0;
      pma_init_q  <= 1'b1;
      reset_pb_q  <= 1'b1;
      link_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pma_tmr_q   <= pma_tmr_d;
      pb_tmr_q    <= pb_tmr_d;
      to_tmr_q    <= to_tmr_d;
      deb_q       <= deb_d;
      retry_cnt_q <= retry_cnt_d;
      pma_init_q  <= pma_init_d;
      reset_pb_q  <= reset_pb_d;
      link_ok_q   <= link_ok_d;
      fail_q      <= fail_d;
    end
  end

  // Each timer fires on the cycle its increment would reach the target, so a state lasts exactly N cycles.
  always_comb begin
    state_d   = state_q;
    pma_tmr_d = pma_tmr_q;
    pb_tmr_d  = pb_tmr_q;
    to_tmr_d  = to_tmr_q;
    deb_d     = deb_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PMA_HOLD;
      end
      S_PMA_HOLD: begin
        pma_tmr_d = pma_tmr_q + 1'b1;
        if (pma_tmr_q >= PMA_W'(PMA_INIT_CYCLES - 1)) state_d = S_PB_HOLD;
      end
      S_PB_HOLD: begin
        if (lock_s) begin
          pb_tmr_d = pb_tmr_q + 1'b1;
          if (pb_tmr_q >= PB_W'(RESET_PB_CYCLES - 1)) state_d = S_WAIT_UP;
        end else begin
          pb_tmr_d = '0;
        end
      end
      S_WAIT_UP: begin
        to_tmr_d = to_tmr_q + 1'b1;
        deb_d    = chan_s ? deb_q + 1'b1 : '0;
        if (chan_s && (deb_q >= DB_W'(DEBOUNCE_CYCLES - 1))) begin
          state_d = S_UP;
        end else if (to_tmr_q >= TO_W'(LINK_TIMEOUT - 1)) begin
          state_d = S_RETRY;
        end
      end
      S_UP: begin
        deb_d = !chan_s ? deb_q + 1'b1 : '0;
        if (!chan_s && (deb_q >= DB_W'(DEBOUNCE_CYCLES - 1))) state_d = S_RETRY;
      end
      S_RETRY: begin
        if ((RETRY_MAX != 0) && (32'(retry_cnt_q) >= RETRY_MAX)) state_d = S_FAIL;
        else                                                     state_d = S_PMA_HOLD;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!enable) state_d = S_IDLE;
    if (state_d != state_q) begin
      pma_tmr_d = '0;
      pb_tmr_d  = '0;
      to_tmr_d  = '0;
      deb_d     = '0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state register.
  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (state_d == S_IDLE) begin
      retry_cnt_d = '0;
    end else if ((state_d == S_RETRY) && (state_q != S_RETRY) && (retry_cnt_q != 8'hFF)) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end
    pma_init_d = (state_d == S_IDLE) || (state_d == S_PMA_HOLD) ||
                 (state_d == S_RETRY) || (state_d == S_FAIL);
    reset_pb_d = pma_init_d || (state_d == S_PB_HOLD);
    link_ok_d  = (state_d == S_UP);
    fail_d     = (state_d == S_FAIL);
  end

  assign pma_init      = pma_init_q;
  assign reset_pb      = reset_pb_q;
  assign link_ok       = link_ok_q;
  assign fail          = fail_q;
  assign state         = state_q;
  assign retry_cnt     = retry_cnt_q;
  assign lanes_up_sync = sync2_q[NUM_LANES-1:0];

`ifdef AURORA_SEQ_STATS_EN
  logic [15:0] down_q;
  logic [31:0] lat_cnt_q, last_lat_q;

  // Latency counts the cycles spent in WAIT_UP; only a successful exit to UP publishes it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      down_q     <= '0;
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      if ((state_q == S_UP) && (state_d == S_RETRY) && (down_q != 16'hFFFF)) begin
        down_q <= down_q + 16'd1;
      end
      if (state_q != S_WAIT_UP) begin
        lat_cnt_q <= '0;
      end else if (lat_cnt_q != 32'hFFFF_FFFF) begin
        lat_cnt_q <= lat_cnt_q + 32'd1;
      end
      if ((state_q == S_WAIT_UP) && (state_d == S_UP)) begin
        last_lat_q <= (lat_cnt_q == 32'hFFFF_FFFF) ? lat_cnt_q : lat_cnt_q + 32'd1;
      end
    end
  end

  assign down_events     = down_q;
  assign last_up_latency = last_lat_q;
`endif

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Self-checking bench for aurora_link_sequencer: each scenario queues the expected state/output
// transitions with their cycle spacing and compares them as the DUT produces them.
module tb_aurora_link_sequencer;

  localparam int NL = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PMA = 3'd1, ST_PB = 3'd2, ST_WAIT = 3'd3,
                         ST_UP = 3'd4, ST_RETRY = 3'd5, ST_FAIL = 3'd6;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          enable;
  logic          gt_pll_lock;
  logic [NL-1:0] lane_up;
  logic          channel_up;
  logic          pma_init;
  logic          reset_pb;
  logic          link_ok;
  logic          fail;
  logic [2:0]    state;
  logic [7:0]    retry_cnt;
  logic [NL-1:0] lanes_up_sync;
`ifdef AURORA_SEQ_STATS_EN
  logic [15:0]   down_events;
  logic [31:0]   last_up_latency;
`endif

  typedef struct {
    logic [14:0] v;
    int          dly;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  always #5 ap_clk = ~ap_clk;

  aurora_link_sequencer #(
    .NUM_LANES(NL), .PMA_INIT_CYCLES(8), .RESET_PB_CYCLES(4),
    .LINK_TIMEOUT(100), .DEBOUNCE_CYCLES(3), .RETRY_MAX(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .gt_pll_lock(gt_pll_lock),
    .lane_up(lane_up), .channel_up(channel_up), .pma_init(pma_init), .reset_pb(reset_pb),
    .link_ok(link_ok), .fail(fail), .state(state), .retry_cnt(retry_cnt),
    .lanes_up_sync(lanes_up_sync)
`ifdef AURORA_SEQ_STATS_EN
    , .down_events(down_events), .last_up_latency(last_up_latency)
`endif
  );

  function automatic logic [14:0] obsVec();
    return {state, pma_init, reset_pb, link_ok, fail, retry_cnt};
  endfunction

  function automatic void pushExp(input logic [2:0] st, input logic pma, input logic rpb,
                                  input logic lok, input logic fl, input logic [7:0] rc,
                                  input int dly);
    exp_t e;
    e.v   = {st, pma, rpb, lok, fl, rc};
    e.dly = dly;
    expQ.push_back(e);
  endfunction

  // Waits (bounded) for the state to change, sampling on falling edges; n counts rising edges seen.
  task automatic nextChange(input int budget, output int n, output bit to);
    logic [2:0] prev;
    prev = state;
    n    = 0;
    to   = 1'b1;
    while (n < budget) begin
      @(negedge ap_clk);
      n++;
      if (state !== prev) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit to;
    #12;
    tests++; if (state !== ST_IDLE) begin fails++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    tests++; if (pma_init !== 1'b1) begin fails++; $display("[TB] FAIL reset_pma: got %b want 1", pma_init); end
    tests++; if (reset_pb !== 1'b1) begin fails++; $display("[TB] FAIL reset_pb: got %b want 1", reset_pb); end
    tests++; if (link_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset_link_ok: got %b want 0", link_ok); end
    tests++; if (fail !== 1'b0) begin fails++; $display("[TB] FAIL reset_fail: got %b want 0", fail); end
    tests++; if (retry_cnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_retry: got %0d want 0", retry_cnt); end
    tests++; if (lanes_up_sync !== 4'h0) begin fails++; $display("[TB] FAIL reset_sync: got %h want 0", lanes_up_sync); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    nextChange(5, n, to);
    tests++; if (!to) begin fails++; $display("[TB] FAIL idle_hold: state moved to %0d want stay 0", state); end
    tests++; if (lanes_up_sync !== 4'hF) begin fails++; $display("[TB] FAIL lanes_sync: got %h want f", lanes_up_sync); end
  endtask

  task automatic test_bringup();
    exp_t e;
    int n;
    bit to;
    @(negedge ap_clk);
    enable = 1'b1;
    pushExp(ST_PMA, 1, 1, 0, 0, 8'd0, 1);
    pushExp(ST_PB, 0, 1, 0, 0, 8'd0, 8);
    pushExp(ST_WAIT, 0, 0, 0, 0, 8'd0, 4);
    for (int k = 0; k < 2; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL bringup_seq: got %h after %0d cycles, want %h after %0d", obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        repeat (10) @(negedge ap_clk);
        channel_up = 1'b1;
        pushExp(ST_UP, 0, 0, 1, 0, 8'd0, 5);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    bit to;
    @(negedge ap_clk);
    channel_up = 1'b0;
    repeat (2) @(negedge ap_clk);
    channel_up = 1'b1;
    nextChange(12, n, to);
    tests++; if (!to) begin fails++; $display("[TB] FAIL glitch_ignored: state moved to %0d want stay 4", state); end
    tests++; if (link_ok !== 1'b1) begin fails++; $display("[TB] FAIL glitch_link_ok: got %b want 1", link_ok); end
  endtask

  task automatic test_down_event();
    exp_t e;
    int n;
    bit to;
    @(negedge ap_clk);
    channel_up = 1'b0;
    pushExp(ST_RETRY, 1, 1, 0, 0, 8'd1, 5);
    for (int k = 0; k < 2; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL down_seq: got %h after %0d cycles, want %h after %0d", obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        channel_up = 1'b1;
        pushExp(ST_PMA, 1, 1, 0, 0, 8'd1, 1);
        pushExp(ST_PB, 0, 1, 0, 0, 8'd1, 8);
        pushExp(ST_WAIT, 0, 0, 0, 0, 8'd1, 4);
        pushExp(ST_UP, 0, 0, 1, 0, 8'd1, 3);
      end
    end
`ifdef AURORA_SEQ_STATS_EN
    tests++; if (down_events !== 16'd1) begin fails++; $display("[TB] FAIL down_events: got %0d want 1", down_events); end
    tests++; if (last_up_latency !== 32'd3) begin fails++; $display("[TB] FAIL up_latency: got %0d want 3", last_up_latency); end
`endif
  endtask

  task automatic test_enable_drop();
    exp_t e;
    int n;
    bit to;
    @(negedge ap_clk);
    enable = 1'b0;
    pushExp(ST_IDLE, 1, 1, 0, 0, 8'd0, 1);
    for (int k = 0; k < 3; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL enable_drop_seq%0d: got %h after %0d cycles, want %h after %0d", k, obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        enable = 1'b1;
        pushExp(ST_PMA, 1, 1, 0, 0, 8'd0, 1);
        pushExp(ST_PB, 0, 1, 0, 0, 8'd0, 8);
      end else if (k == 1) begin
        @(negedge ap_clk);
        enable = 1'b0;
        pushExp(ST_IDLE, 1, 1, 0, 0, 8'd0, 1);
      end
    end
  endtask

  task automatic test_pll_lock();
    exp_t e;
    int n;
    bit to;
    int bad;
    @(negedge ap_clk);
    gt_pll_lock = 1'b0;
    channel_up  = 1'b0;
    repeat (3) @(negedge ap_clk);
    enable = 1'b1;
    pushExp(ST_PMA, 1, 1, 0, 0, 8'd0, 1);
    pushExp(ST_PB, 0, 1, 0, 0, 8'd0, 8);
    for (int k = 0; k < 2; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL pll_seq: got %h after %0d cycles, want %h after %0d", obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        bad = 0;
        repeat (20) begin
          @(negedge ap_clk);
          if (reset_pb !== 1'b1 || state !== ST_PB) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL pll_hold: %0d bad cycles want 0", bad); end
        gt_pll_lock = 1'b1;
        pushExp(ST_WAIT, 0, 0, 0, 0, 8'd0, 6);
      end
    end
  endtask

  task automatic test_timeout_fail();
    exp_t e;
    int n;
    bit to;
    pushExp(ST_RETRY, 1, 1, 0, 0, 8'd1, 100);
    pushExp(ST_PMA, 1, 1, 0, 0, 8'd1, 1);
    pushExp(ST_PB, 0, 1, 0, 0, 8'd1, 8);
    pushExp(ST_WAIT, 0, 0, 0, 0, 8'd1, 4);
    pushExp(ST_RETRY, 1, 1, 0, 0, 8'd2, 100);
    pushExp(ST_FAIL, 1, 1, 0, 1, 8'd2, 1);
    for (int k = 0; k < 2; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL timeout_seq: got %h after %0d cycles, want %h after %0d", obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        nextChange(10, n, to);
        tests++; if (!to) begin fails++; $display("[TB] FAIL fail_sticky: state moved to %0d want stay 6", state); end
        enable = 1'b0;
        pushExp(ST_IDLE, 1, 1, 0, 0, 8'd0, 1);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int n;
    bit to;
    @(negedge ap_clk);
    enable = 1'b1;
    pushExp(ST_PMA, 1, 1, 0, 0, 8'd0, 1);
    pushExp(ST_PB, 0, 1, 0, 0, 8'd0, 8);
    pushExp(ST_WAIT, 0, 0, 0, 0, 8'd0, 4);
    for (int k = 0; k < 2; k++) begin
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        nextChange(200, n, to);
        tests++;
        if (to || obsVec() !== e.v || n != e.dly) begin
          fails++;
          $display("[TB] FAIL async_seq%0d: got %h after %0d cycles, want %h after %0d", k, obsVec(), n, e.v, e.dly);
        end
      end
      if (k == 0) begin
        repeat (5) @(negedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1;
        tests++;
        if (obsVec() !== {ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0} || lanes_up_sync !== 4'h0) begin
          fails++;
          $display("[TB] FAIL async_reset: got %h sync %h, want %h sync 0", obsVec(), lanes_up_sync,
                   {ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        pushExp(ST_PMA, 1, 1, 0, 0, 8'd0, 1);
        pushExp(ST_PB, 0, 1, 0, 0, 8'd0, 8);
        pushExp(ST_WAIT, 0, 0, 0, 0, 8'd0, 4);
      end
    end
  endtask

  initial begin
    ap_rst_n    = 1'b0;
    enable      = 1'b0;
    gt_pll_lock = 1'b1;
    lane_up     = 4'hF;
    channel_up  = 1'b0;
    test_reset();
    test_bringup();
    test_glitch();
    test_down_event();
    test_enable_drop();
    test_pll_lock();
    test_timeout_fail();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
